// File: rtl/s4ga_pkg.sv
// Shared sizing helpers for the s4ga LUT fabric family and its testbenches.
// Derives select width, configuration word width and beats per LUT.
package s4ga_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2)
            r++;
        return r;
    endfunction

    function automatic int calc_iw(input int n, input int i);
        return clog2(n + i);
    endfunction

    function automatic int calc_w(input int k, input int iw);
        return (1 << k) + k * iw;
    endfunction

    function automatic int calc_cpl(input int w, input int si_w);
        return (w + si_w - 1) / si_w;
    endfunction

endpackage

// File: rtl/s4ga2_lut_eval.sv
// Combinational evaluation of one K-input LUT configuration word.
// Each select addresses {ext_s, lut_q}; selects past the end of that space read 0.
module s4ga2_lut_eval
    import s4ga_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 4,
    parameter int I = 4
) (
    input  logic [calc_w(K, calc_iw(N, I))-1:0] word,
    input  logic [N-1:0]                        lut_q,
    input  logic [I-1:0]                        ext_s,
    output logic                                y
);
    localparam int IW = calc_iw(N, I);
    localparam int T  = 1 << K;
    localparam int S  = N + I;

    logic [S-1:0]  src;
    logic [T-1:0]  truth;
    logic [K-1:0]  addr;
    logic [IW-1:0] sel;

    assign src   = {ext_s, lut_q};
    assign truth = word[T-1:0];

    always_comb begin
        addr = '0;
        sel  = '0;
        for (int j = 0; j < K; j++) begin
            sel     = word[T + j * IW +: IW];
            addr[j] = (int'(sel) < S) ? src[sel] : 1'b0;
        end
    end

    assign y = truth[addr];

endmodule

// File: rtl/s4ga2.sv
// Serially configured LUT fabric: beats assemble a LUT word, each completed word
// rewrites one LUT. Build with S4GA2_SNAPSHOT_EN for a once-per-frame output register.
module s4ga2
    import s4ga_pkg::*;
#(
    parameter int N    = 16,
    parameter int K    = 4,
    parameter int SI_W = 4,
    parameter int I    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SI_W-1:0] si,
    input  logic            si_valid,
    input  logic [I-1:0]    ext_in,
    output logic [N-1:0]    luts,
    output logic            frame
);
    localparam int IW  = calc_iw(N, I);
    localparam int W   = calc_w(K, IW);
    localparam int CPL = calc_cpl(W, SI_W);
    localparam int WR  = CPL * SI_W;
    localparam int BW  = (CPL > 1) ? clog2(CPL) : 1;
    localparam int XW  = clog2(N);

    logic [WR-1:0] word, word_full;
    logic [BW-1:0] beat;
    logic [XW-1:0] idx;
    logic [N-1:0]  lut_q, lut_next;
    logic [I-1:0]  ext_m, ext_s;
    logic          last_beat, last_lut, wr_en, y;

    // The word being completed includes the beat presented this cycle.
    generate
        if (CPL > 1) begin : g_multi
            assign word_full = {si, word[WR-1:SI_W]};
        end else begin : g_single
            assign word_full = si;
        end
    endgenerate

    assign last_beat = (beat == BW'(CPL - 1));
    assign last_lut  = (idx == XW'(N - 1));
    assign wr_en     = si_valid && last_beat;

    s4ga2_lut_eval #(.N(N), .K(K), .I(I)) u_eval (
        .word  (word_full[W-1:0]),
        .lut_q (lut_q),
        .ext_s (ext_s),
        .y     (y)
    );

    always_comb begin
        lut_next = lut_q;
        if (wr_en)
            lut_next[idx] = y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word  <= '0;
            beat  <= '0;
            idx   <= '0;
            lut_q <= '0;
            ext_m <= '0;
            ext_s <= '0;
            frame <= 1'b0;
        end else begin
            ext_m <= ext_in;
            ext_s <= ext_m;
            frame <= wr_en && last_lut;
            lut_q <= lut_next;
            if (si_valid) begin
                word <= word_full;
                beat <= last_beat ? '0 : beat + 1'b1;
                if (last_beat)
                    idx <= last_lut ? '0 : idx + 1'b1;
            end
        end
    end

`ifdef S4GA2_SNAPSHOT_EN
    logic [N-1:0] snap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            snap <= '0;
        else if (wr_en && last_lut)
            snap <= lut_next;
    end

    assign luts = snap;
`else
    assign luts = lut_q;
`endif

endmodule

// File: tb/tb_s4ga2.sv
// Directed bench for s4ga2 at N=16, K=4, SI_W=4, I=4 (36-bit words, 9 beats, 144 beats/frame).
// Expectations switch with S4GA2_SNAPSHOT_EN where luts timing differs.
module tb_s4ga2;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  si;
    logic        si_valid;
    logic [3:0]  ext_in;
    logic [15:0] luts;
    logic        frame;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nframes = 0;
    int last_frame_cyc = 0;
    int prev_frame_cyc = 0;
    int snap_err = 0;
    logic [15:0] snap_ref = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    s4ga2 dut (
        .clk      (clk),
        .rst      (rst),
        .si       (si),
        .si_valid (si_valid),
        .ext_in   (ext_in),
        .luts     (luts),
        .frame    (frame)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [3:0] v);
        si = v;
        si_valid = 1'b1;
        @(posedge clk);
        #1;
        if (frame) begin
            nframes++;
            prev_frame_cyc = last_frame_cyc;
            last_frame_cyc = cyc;
            snap_ref = luts;
        end else if (luts !== snap_ref) begin
            snap_err++;
        end
    endtask

    task automatic word_part(input logic [15:0] t, input logic [4:0] s, input int from, input int upto);
        logic [35:0] w;
        w = {s, s, s, s, t};
        for (int b = from; b < upto; b++)
            send_beat(w[4*b +: 4]);
    endtask

    task automatic send_word(input logic [15:0] t, input logic [4:0] s);
        word_part(t, s, 0, 9);
    endtask

    task automatic send_frame(input logic [15:0] t0, input logic [4:0] s0,
                              input logic [15:0] t1, input logic [4:0] s1);
        send_word(t0, s0);
        send_word(t1, s1);
        for (int n = 0; n < 14; n++)
            send_word(16'h0000, 5'd0);
    endtask

    task automatic idle(input int n);
        si_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; si = '0; si_valid = 1'b0; ext_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_luts", luts, 0);
        chk("rst_frame", frame, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // constant-one LUT0
        word_part(16'hFFFF, 5'd0, 0, 8);
        chk("t1_beat8", luts, 0);
        word_part(16'hFFFF, 5'd0, 8, 9);
`ifdef S4GA2_SNAPSHOT_EN
        chk("t1_beat9", luts, 16'h0000);
`else
        chk("t1_beat9", luts, 16'h0001);
`endif
        for (int n = 0; n < 14; n++)
            send_word(16'h0000, 5'd0);
        word_part(16'h0000, 5'd0, 0, 8);
        chk("t1_pre_frame", frame, 0);
        word_part(16'h0000, 5'd0, 8, 9);
        chk("t1_frame", frame, 1);
        chk("t1_luts", luts, 16'h0001);
        chk("t1_nframes", nframes, 1);

        // ring oscillator on LUT0
        send_frame(16'h0001, 5'd0, 16'h0000, 5'd0);
        chk("t2a_frame", frame, 1);
        chk("t2a_luts", luts, 16'h0000);
        send_frame(16'h0001, 5'd0, 16'h0000, 5'd0);
        chk("t2b_luts", luts, 16'h0001);
        chk("t2_period", last_frame_cyc - prev_frame_cyc, 144);
        chk("t2_nframes", nframes, 3);
        idle(1);
        chk("t2_frame_low", frame, 0);

        // external input through the synchroniser
        ext_in = 4'b0001;
        idle(4);
        send_word(16'h0001, 5'd0);
        send_word(16'h8000, 5'd16);
`ifndef S4GA2_SNAPSHOT_EN
        chk("t3_lut1_mid", luts[1:0], 2'b10);
`endif
        for (int n = 0; n < 14; n++)
            send_word(16'h0000, 5'd0);
        chk("t3_ext_set", luts, 16'h0002);
        ext_in = 4'b0010;
        send_frame(16'h0001, 5'd0, 16'h8000, 5'd16);
        chk("t3_ext_clr", luts, 16'h0001);

        // stall mid-word after a fresh reset
        si_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("t4_rst_luts", luts, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        word_part(16'hFFFF, 5'd0, 0, 5);
        for (int n = 0; n < 5; n++) begin
            si_valid = 1'b0;
            si = 4'hA;
            @(posedge clk); #1;
            chk("t4_stall_luts", luts, 0);
            chk("t4_stall_frame", frame, 0);
        end
        word_part(16'hFFFF, 5'd0, 5, 8);
        chk("t4_beat8", luts, 0);
        word_part(16'hFFFF, 5'd0, 8, 9);
`ifdef S4GA2_SNAPSHOT_EN
        chk("t4_beat9", luts, 16'h0000);
`else
        chk("t4_beat9", luts, 16'h0001);
`endif

        // asynchronous reset partway through LUT3
        send_word(16'h0000, 5'd0);
        send_word(16'h0000, 5'd0);
        word_part(16'hFFFF, 5'd0, 0, 7);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_rst_luts", luts, 0);
        chk("t5_rst_frame", frame, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        nframes = 0;
        send_word(16'hFFFF, 5'd0);
`ifdef S4GA2_SNAPSHOT_EN
        chk("t5_lut0", luts, 16'h0000);
`else
        chk("t5_lut0", luts, 16'h0001);
`endif
        for (int n = 0; n < 15; n++)
            send_word(16'h0000, 5'd0);
        chk("t5_frame", frame, 1);
        chk("t5_luts", luts, 16'h0001);
        chk("t5_nframes", nframes, 1);

`ifdef S4GA2_SNAPSHOT_EN
        // snapshot register holds between frame strobes
        snap_err = 0;
        snap_ref = luts;
        send_word(16'h0001, 5'd0);
        chk("t6_lutq0", dut.lut_q[0], 0);
        chk("t6_luts_hold", luts, 16'h0001);
        for (int n = 0; n < 15; n++)
            send_word(16'h0000, 5'd0);
        chk("t6_frame_a", luts, 16'h0000);
        send_frame(16'h0001, 5'd0, 16'h0000, 5'd0);
        chk("t6_frame_b", luts, 16'h0001);
        chk("t6_stable", snap_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/s4ga2.md
# s4ga2

Second-generation serially configured LUT fabric. Configuration words stream in continuously on a narrow serial bus. Each complete word defines one K-input LUT, which is evaluated immediately and written into an N-entry LUT state vector, so the fabric is re-evaluated LUT by LUT, frame after frame. Compared with s4ga, this block adds:
- synchronised external inputs in the select space,
- an `si_valid` stall handshake,
- a frame strobe,
- optional glitch-free output snapshots.

It sits directly behind the chip I/O wrapper.

## Interface
Parameters
- N, 16, number of LUTs (≥2)
- K, 4, LUT inputs (1..6)
- SI_W, 4, serial config beat width
- I, 4, external inputs
- derived: IW = clog2(N+I); W = 2^K + K·IW; CPL = ceil(W/SI_W) beats per LUT

Ports
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- si  in  SI_W  config beat
- si_valid  in  1  beat accepted when high
- ext_in  in  I  asynchronous external inputs
- luts  out  N  LUT outputs
- frame  out  1  one-cycle pulse after LUT N-1 is written

## Operation
**Beat assembly**
- Accepted beats shift into a CPL·SI_W word register, LSB-first: beat 0 carries word bits [SI_W-1:0].
- The beat counter `beat` runs 0..CPL-1 and advances only on accepted beats.

**Word layout**
- truth[2^K-1:0] at bits [2^K-1:0].
- sel_j at [2^K + j·IW +: IW], for j = 0..K-1.
- Bits ≥ W are padding and are ignored.

**Select space**
- sel < N reads lut_q[sel], the current value, so LUT j sees values already written earlier in the same frame.
- N ≤ sel < N+I reads ext_s[sel-N].
- sel ≥ N+I reads 0.

**Evaluation**
- On the accepted beat with beat == CPL-1, the word (including the current beat) is evaluated combinationally.
- addr = {in_{K-1}..in_0}; lut_q[idx] <= truth[addr].
- idx then increments; at N-1 it wraps to 0 and frame is asserted the next cycle.

**Other behaviour**
- ext_in passes through a 2-flop synchroniser to ext_s.
- Stall: while si_valid = 0, word, beat, idx, lut_q and frame hold (frame is 0).
- Reset (asynchronous, any time including mid-word): lut_q = 0, beat = 0, idx = 0, word = 0, ext_s = 0, frame = 0, luts = 0. The first accepted beat after reset release is beat 0 of LUT 0.

## Timing
- Update latency: lut_q[idx] changes at the clock edge that accepts the final beat; there is no extra pipeline stage.
- Frame length: N·CPL accepted beats.
- External input latency: 2 cycles (synchroniser), plus the wait until the consuming LUT is next evaluated (up to one frame).
- frame: high for exactly one cycle, the cycle after the edge that writes LUT N-1, even if si_valid drops in that cycle.
- Without snapshot, luts = lut_q and may change once per CPL accepted beats.

## Configuration
- Macro: S4GA2_SNAPSHOT_EN.
- Defined: luts is driven from a separate N-bit register. On the edge that writes LUT N-1, it loads lut_q with that write already applied. luts therefore changes only once per frame, coincident with frame rising, and resets to 0.
- Undefined: luts = lut_q directly, with no extra register.

## Structure
- Package s4ga_pkg: clog2 function, and W/CPL/IW computation functions shared with s4ga and testbenches.
- Sub-module s4ga2_lut_eval is purely combinational:
  - inputs: word, lut_q, ext_s
  - output: the LUT result bit
  - contains the K select muxes and the truth-table index
- s4ga2 itself holds the word register, counters, synchroniser, lut_q, the frame strobe and the snapshot register.

## Test plan
All tests use N=16, K=4, SI_W=4, I=4, giving IW=5, W=36, CPL=9, and 144 beats per frame.
1. Constant: LUT0 word truth=16'hFFFF, sels=0. After 9 accepted beats, luts[0]=1 (luts[0] rises at the 9th beat edge, non-snapshot); all other luts stay 0.
2. Ring oscillator: LUT0 with sels=0, truth=16'h0001, and LUTs 1..15 all-zero words, streamed repeatedly. luts[0] toggles once per 144 beats; frame pulses every 144 cycles with si_valid held high.
3. External pass: LUT1 sels=16, truth=16'h8000; set ext_in[0]=1. luts[1]=1 at the first LUT1 evaluation at least 2 cycles after the change. Clearing ext_in[0] gives 0 on the next frame.
4. Stall: drop si_valid for 5 cycles mid-word (after beat 4). The result and its timing in accepted beats are identical to test 1; no state changes during the stall.
5. Reset mid-word: assert rst after beat 6 of LUT3. luts=0 and frame=0 immediately. The next 9 beats configure LUT0, not LUT3.
6. Snapshot, with S4GA2_SNAPSHOT_EN: run test 2. luts changes only in frame cycles; lut_q differs from luts mid-frame.
